// File: rtl/rob_commit.sv
// rob_commit: in-order retirement at the ROB head; owns head pointer and occupancy.
// Retires results to the register file, drains stores over req/ack and halts on ecall.
module rob_commit #(
    parameter int unsigned ROB_SIZE  = 16,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned REG_BITS  = 5,
    localparam int unsigned ROB_TAGW = $clog2(ROB_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic                 head_ready,
    input  logic [REG_BITS-1:0]  head_rd,
    input  logic [DATA_SIZE-1:0] head_value,
    input  logic [DATA_SIZE-1:0] head_addr,
    input  logic                 head_store,
    input  logic [1:0]           head_size,
    input  logic                 head_ecall,
    input  logic                 head_nowb,
    input  logic [ROB_TAGW-1:0]  mt_tag_rd,
    input  logic                 st_ack,
    output logic [ROB_TAGW-1:0]  rob_head,
    output logic [ROB_TAGW-1:0]  rob_tail,
    output logic [ROB_TAGW-1:0]  rob_count,
    output logic                 rob_full,
    output logic                 rob_empty,
    output logic                 retire_valid,
    output logic [ROB_TAGW-1:0]  retire_tag,
    output logic                 rf_we,
    output logic [REG_BITS-1:0]  rf_waddr,
    output logic [DATA_SIZE-1:0] rf_wdata,
    output logic                 mt_clear,
    output logic                 st_req,
    output logic [DATA_SIZE-1:0] st_addr,
    output logic [DATA_SIZE-1:0] st_data,
    output logic [1:0]           st_size,
    output logic                 halted,
    output logic                 overflow_err
);

    typedef enum logic [1:0] {StRun, StStWait, StHalt} state_e;

    localparam logic [ROB_TAGW-1:0] TagFirst = ROB_TAGW'(1);
    localparam logic [ROB_TAGW-1:0] TagLast  = ROB_TAGW'(ROB_SIZE);

    state_e                 state_q, state_d;
    logic [ROB_TAGW-1:0]    head_q, head_d;
    logic [ROB_TAGW-1:0]    tail_q, tail_d;
    logic [ROB_TAGW-1:0]    count_q, count_d;
    logic                   st_req_q, st_req_d;
    logic [DATA_SIZE-1:0]   st_addr_q, st_addr_d;
    logic [DATA_SIZE-1:0]   st_data_q, st_data_d;
    logic [1:0]             st_size_q, st_size_d;
    logic                   halted_q, halted_d;
    logic                   overflow_q, overflow_d;
    logic                   retire;
    logic                   wb_en;
    logic                   alloc_acc;

    // Tags are 1-based, so the pointer wraps from ROB_SIZE back to 1.
    function automatic logic [ROB_TAGW-1:0] tag_inc(input logic [ROB_TAGW-1:0] t);
        return (t == TagLast) ? TagFirst : t + ROB_TAGW'(1);
    endfunction

    assign rob_empty = (count_q == '0);
    assign rob_full  = (count_q == TagLast);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        st_req_d   = st_req_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        st_size_d  = st_size_q;
        halted_d   = halted_q;
        overflow_d = overflow_q;
        retire     = 1'b0;
        wb_en      = 1'b0;

        case (state_q)
            StRun: begin
                if (!reset && !rob_empty && head_ready) begin
                    if (head_store) begin
                        st_req_d  = 1'b1;
                        st_addr_d = head_addr;
                        st_data_d = head_value;
                        st_size_d = head_size;
                        state_d   = StStWait;
                    end else if (head_ecall) begin
                        retire   = 1'b1;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        retire = 1'b1;
                        wb_en  = !head_nowb && (head_rd != '0);
                    end
                end
            end
            StStWait: begin
                if (!reset && st_ack) begin
                    retire   = 1'b1;
                    st_req_d = 1'b0;
                    state_d  = StRun;
                end
            end
            StHalt: begin
            end
            default: state_d = StRun;
        endcase

        // A retire frees a slot in the same cycle, so alloc is legal even when full.
        alloc_acc = alloc_valid && (!rob_full || retire);
        if (alloc_valid && rob_full && !retire) begin
            overflow_d = 1'b1;
        end
        if (retire) begin
            head_d = tag_inc(head_q);
        end
        if (alloc_acc) begin
            tail_d = tag_inc(tail_q);
        end
        case ({alloc_acc, retire})
            2'b10:   count_d = count_q + ROB_TAGW'(1);
            2'b01:   count_d = count_q - ROB_TAGW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            head_q     <= TagFirst;
            tail_q     <= TagFirst;
            count_q    <= '0;
            st_req_q   <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            st_size_q  <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            st_req_q   <= st_req_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            st_size_q  <= st_size_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
        end
    end

    assign rob_head     = head_q;
    assign rob_tail     = tail_q;
    assign rob_count    = count_q;
    assign retire_valid = retire;
    assign retire_tag   = retire ? head_q : '0;
    assign rf_we        = wb_en;
    assign rf_waddr     = wb_en ? head_rd : '0;
    assign rf_wdata     = wb_en ? head_value : '0;
    // A newer in-flight writer of the same register keeps its mapping.
    assign mt_clear     = wb_en && (mt_tag_rd == head_q);
    assign st_req       = st_req_q;
    assign st_addr      = st_addr_q;
    assign st_data      = st_data_q;
    assign st_size      = st_size_q;
    assign halted       = halted_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: randomized and directed stimulus against a queue-based ROB model;
// expected status and retire events are queued by the driver and checked by a monitor.
module tb_rob_commit;

    localparam int ROB_SIZE = 16;
    localparam int TW       = 5;

    typedef struct {
        int        tag;
        bit [4:0]  rd;
        bit [31:0] value;
        bit [31:0] addr;
        bit        store;
        bit [1:0]  size;
        bit        ecall;
        bit        nowb;
    } ent_t;

    typedef struct {
        int        head;
        int        tail;
        int        count;
        bit        halt;
        bit        ovf;
        bit        sreq;
        bit [31:0] saddr;
        bit [31:0] sdata;
        bit [1:0]  ssize;
    } stat_t;

    typedef struct {
        int        cyc;
        int        tag;
        bit        we;
        bit [4:0]  waddr;
        bit [31:0] wdata;
        bit        mtc;
    } ret_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          head_ready = 1'b0;
    logic [4:0]    head_rd = '0;
    logic [31:0]   head_value = '0;
    logic [31:0]   head_addr = '0;
    logic          head_store = 1'b0;
    logic [1:0]    head_size = '0;
    logic          head_ecall = 1'b0;
    logic          head_nowb = 1'b0;
    logic [TW-1:0] mt_tag_rd = '0;
    logic          st_ack = 1'b0;
    logic [TW-1:0] rob_head, rob_tail, rob_count, retire_tag;
    logic          rob_full, rob_empty, retire_valid, rf_we, mt_clear, st_req, halted;
    logic          overflow_err;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata, st_addr, st_data;
    logic [1:0]    st_size;

    rob_commit #(.ROB_SIZE(16), .DATA_SIZE(32), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .head_ready(head_ready),
        .head_rd(head_rd), .head_value(head_value), .head_addr(head_addr),
        .head_store(head_store), .head_size(head_size), .head_ecall(head_ecall),
        .head_nowb(head_nowb), .mt_tag_rd(mt_tag_rd), .st_ack(st_ack),
        .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count),
        .rob_full(rob_full), .rob_empty(rob_empty), .retire_valid(retire_valid),
        .retire_tag(retire_tag), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mt_clear(mt_clear), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
        .st_size(st_size), .halted(halted), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model: ROB contents as an ordered queue plus sticky flags.
    ent_t      rob[$];
    int        m_head = 1, m_tail = 1;
    bit        m_pend = 0, m_halt = 0, m_ovf = 0;
    bit [31:0] m_saddr = 0, m_sdata = 0;
    bit [1:0]  m_ssize = 0;

    stat_t stat_q[$];
    ret_t  ret_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic int nxt(int t);
        return (t == ROB_SIZE) ? 1 : t + 1;
    endfunction

    function automatic ent_t mk(bit [4:0] rd, bit [31:0] v, bit st, bit [31:0] a, bit ec,
                                bit nowb, bit [1:0] sz);
        ent_t e;
        e.tag = 0; e.rd = rd; e.value = v; e.store = st; e.addr = a;
        e.ecall = ec; e.nowb = nowb; e.size = sz;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        int   k;
        k = $urandom_range(99);
        e.tag = 0;
        e.rd = 5'($urandom);
        e.value = $urandom;
        e.addr = $urandom;
        e.size = 2'($urandom_range(2));
        e.store = (k < 15);
        e.ecall = (k >= 15 && k < 17);
        e.nowb = e.store || ($urandom_range(9) == 0);
        return e;
    endfunction

    // One clock cycle: queue expectations, drive inputs, advance the model.
    task automatic step(input bit rst, input bit alloc, input ent_t ne, input bit rdy,
                        input bit ack, input int mt);
        stat_t s;
        ret_t  r;
        ent_t  h;
        bit    retire, acc;
        int    mtv;
        @(posedge clk);
        #1;
        s.head = m_head; s.tail = m_tail; s.count = rob.size(); s.halt = m_halt;
        s.ovf = m_ovf; s.sreq = m_pend; s.saddr = m_saddr; s.sdata = m_sdata;
        s.ssize = m_ssize;
        stat_q.push_back(s);

        h = (rob.size() > 0) ? rob[0] : rand_ent();
        mtv = (mt < 0) ? m_head : mt;
        reset = rst; alloc_valid = alloc; head_ready = rdy; st_ack = ack;
        head_rd = h.rd; head_value = h.value; head_addr = h.addr; head_store = h.store;
        head_size = h.size; head_ecall = h.ecall; head_nowb = h.nowb;
        mt_tag_rd = TW'(mtv);

        retire = 0;
        r.cyc = cyc; r.tag = m_head; r.we = 0; r.waddr = 0; r.wdata = 0; r.mtc = 0;
        if (rst) begin
            rob.delete();
            m_head = 1; m_tail = 1; m_pend = 0; m_halt = 0; m_ovf = 0;
            m_saddr = 0; m_sdata = 0; m_ssize = 0;
        end else begin
            if (m_halt) begin
                retire = 0;
            end else if (m_pend) begin
                if (ack) begin
                    retire = 1;
                    m_pend = 0;
                end
            end else if (rob.size() > 0 && rdy) begin
                if (h.store) begin
                    m_pend = 1; m_saddr = h.addr; m_sdata = h.value; m_ssize = h.size;
                end else if (h.ecall) begin
                    retire = 1;
                    m_halt = 1;
                end else begin
                    retire = 1;
                    r.we = !h.nowb && (h.rd != 0);
                    r.waddr = h.rd;
                    r.wdata = h.value;
                    r.mtc = r.we && (mtv == m_head);
                end
            end
            acc = alloc && (rob.size() < ROB_SIZE || retire);
            if (alloc && !acc) m_ovf = 1;
            if (retire) begin
                ret_q.push_back(r);
                void'(rob.pop_front());
                m_head = nxt(m_head);
            end
            if (acc) begin
                ne.tag = m_tail;
                rob.push_back(ne);
                m_tail = nxt(m_tail);
            end
        end
    endtask

    stat_t ms;
    ret_t  mr;
    always @(negedge clk) begin
        if (stat_q.size() > 0) begin
            ms = stat_q.pop_front();
            chk("rob_head", rob_head, ms.head);
            chk("rob_tail", rob_tail, ms.tail);
            chk("rob_count", rob_count, ms.count);
            chk("rob_full", rob_full, ms.count == ROB_SIZE);
            chk("rob_empty", rob_empty, ms.count == 0);
            chk("halted", halted, ms.halt);
            chk("overflow_err", overflow_err, ms.ovf);
            chk("st_req", st_req, ms.sreq);
            if (ms.sreq) begin
                chk("st_addr", st_addr, ms.saddr);
                chk("st_data", st_data, ms.sdata);
                chk("st_size", st_size, ms.ssize);
            end
        end
        if (ret_q.size() > 0 && ret_q[0].cyc < cyc) begin
            chk("retire_missing", ret_q[0].cyc, cyc);
            void'(ret_q.pop_front());
        end
        if (retire_valid === 1'b1) begin
            if (ret_q.size() == 0 || ret_q[0].cyc != cyc) begin
                chk("retire_unexpected", retire_valid, 0);
            end else begin
                mr = ret_q.pop_front();
                chk("retire_tag", retire_tag, mr.tag);
                chk("rf_we", rf_we, mr.we);
                chk("mt_clear", mt_clear, mr.mtc);
                if (mr.we) begin
                    chk("rf_waddr", rf_waddr, mr.waddr);
                    chk("rf_wdata", rf_wdata, mr.wdata);
                end
            end
        end else begin
            chk("write_without_retire", {rf_we, mt_clear}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e0;
        bit   rst_r, al_r, rdy_r, ack_r;
        int   mt_r;
        e0 = mk(0, 0, 0, 0, 0, 1, 0);

        step(1, 0, e0, 0, 0, 0);
        step(1, 0, e0, 0, 0, 0);
        step(0, 0, e0, 1, 0, 0);

        // Three ALU results, then retire back-to-back
        step(0, 1, mk(5, 32'hA, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 1, mk(6, 32'hB, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 1, mk(0, 32'hC, 0, 0, 0, 0, 0), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, e0, 1, 0, -1);
        step(0, 0, e0, 0, 0, 0);

        // Head tag 4: matching map tag clears, tag 5 with stale tag 9 does not
        step(0, 1, mk(7, 32'h44, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 0, e0, 1, 0, 4);
        step(0, 1, mk(7, 32'h55, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 0, e0, 1, 0, 9);

        // Fill, alloc+retire while full, then overflow
        step(1, 0, e0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, mk(5'(i + 1), 32'(i), 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 1, mk(9, 32'h99, 0, 0, 0, 0, 0), 1, 0, -1);
        step(0, 1, mk(9, 32'h98, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 0, e0, 0, 0, 0);

        // Store with ack on the third request cycle, then the next entry
        step(1, 0, e0, 0, 0, 0);
        step(0, 1, mk(0, 32'hDEAD, 1, 32'h100, 0, 1, 2), 0, 0, 0);
        step(0, 1, mk(3, 32'h33, 0, 0, 0, 0, 0), 1, 0, 0);
        step(0, 0, e0, 1, 0, 0);
        step(0, 0, e0, 1, 0, 0);
        step(0, 0, e0, 1, 1, 0);
        step(0, 0, e0, 1, 0, -1);
        step(0, 0, e0, 0, 0, 0);

        // Reset while waiting for a store ack
        step(0, 1, mk(0, 32'hBEEF, 1, 32'h200, 0, 1, 1), 0, 0, 0);
        step(0, 0, e0, 1, 0, 0);
        step(0, 0, e0, 1, 0, 0);
        step(1, 0, e0, 0, 0, 0);
        step(0, 0, e0, 0, 0, 0);

        // Ecall followed by ready entries; allocs still counted while halted
        step(0, 1, mk(0, 0, 0, 0, 1, 1, 0), 0, 0, 0);
        step(0, 1, mk(8, 32'h88, 0, 0, 0, 0, 0), 0, 0, 0);
        step(0, 1, mk(9, 32'h99, 0, 0, 0, 0, 0), 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, (i < 2), mk(4, 32'h4, 0, 0, 0, 0, 0), 1, 0, -1);
        step(1, 0, e0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_r = m_halt ? ($urandom_range(9) == 0) : ($urandom_range(399) == 0);
            al_r  = ($urandom_range(99) < 55);
            rdy_r = ($urandom_range(99) < 65);
            ack_r = m_pend && ($urandom_range(99) < 40);
            mt_r  = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(ROB_SIZE));
            step(rst_r, al_r, rand_ent(), rdy_r, ack_r, mt_r);
        end
        step(0, 0, e0, 0, 0, 0);
        step(0, 0, e0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("retire_queue_drained", ret_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
